// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: opcode -> format, illegal flag and
// sign-extended immediate at XLEN bits.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_fmt_e        fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Classify the major opcode into an immediate format.
    always_comb begin
        fmt = FMT_NONE;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
            OPC_STORE:                                                fmt = FMT_S;
            OPC_BRANCH:                                               fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                                       fmt = FMT_U;
            OPC_JAL:                                                  fmt = FMT_J;
            OPC_OP, OPC_OP_32:                                        fmt = FMT_R;
            OPC_OP_IMM_32: begin
                // Word-immediate ops only exist on RV64.
                if (XLEN == 64) fmt = FMT_I;
            end
            default:                                                  fmt = FMT_NONE;
        endcase
        illegal = (fmt == FMT_NONE);
    end

    // Assemble the 32-bit immediate for the decoded format.
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                            1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast replicates bit 31 up to XLEN.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic valid/ready pipeline around the immediate decoder. Decoded fields and
// the pc travel through PIPE_DEPTH stage registers; pc + imm is formed after the
// last stage so the adder sits directly in front of the consumer.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned PIPE_DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output imm_fmt_e        out_fmt,
    output logic            out_illegal
);

    localparam int unsigned LAST_STAGE = PIPE_DEPTH - 1;

    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr  (in_instr),
        .fmt    (dec_fmt),
        .illegal(dec_illegal),
        .imm    (dec_imm)
    );

    // Stage registers.
    logic            valid_q   [PIPE_DEPTH];
    imm_fmt_e        fmt_q     [PIPE_DEPTH];
    logic            illegal_q [PIPE_DEPTH];
    logic [XLEN-1:0] imm_q     [PIPE_DEPTH];
    logic [XLEN-1:0] pc_q      [PIPE_DEPTH];

    // Upstream view of each stage.
    logic            src_valid   [PIPE_DEPTH];
    imm_fmt_e        src_fmt     [PIPE_DEPTH];
    logic            src_illegal [PIPE_DEPTH];
    logic [XLEN-1:0] src_imm     [PIPE_DEPTH];
    logic [XLEN-1:0] src_pc      [PIPE_DEPTH];

    // load_ok[k]: stage k may capture this cycle; load_ok[PIPE_DEPTH] is the consumer.
    logic [PIPE_DEPTH:0] load_ok;

    // Ready ripples back from the consumer: a stage may load when empty or when
    // its current occupant moves on in the same cycle. in_valid is not involved.
    always_comb begin
        load_ok             = '0;
        load_ok[PIPE_DEPTH] = out_ready;
        for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
            load_ok[k] = ~valid_q[k] | load_ok[k+1];
        end
    end

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_valid[k]   = in_valid;
            assign src_fmt[k]     = dec_fmt;
            assign src_illegal[k] = dec_illegal;
            assign src_imm[k]     = dec_imm;
            assign src_pc[k]      = in_pc;
        end else begin : g_body
            assign src_valid[k]   = valid_q[k-1];
            assign src_fmt[k]     = fmt_q[k-1];
            assign src_illegal[k] = illegal_q[k-1];
            assign src_imm[k]     = imm_q[k-1];
            assign src_pc[k]      = pc_q[k-1];
        end

        // Stage k: take the upstream entry when allowed; flush only drops occupancy.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[k]   <= 1'b0;
                fmt_q[k]     <= FMT_NONE;
                illegal_q[k] <= 1'b0;
                imm_q[k]     <= '0;
                pc_q[k]      <= '0;
            end else begin
                if (flush) begin
                    valid_q[k] <= 1'b0;
                end else if (load_ok[k]) begin
                    valid_q[k] <= src_valid[k];
                end
                if (load_ok[k] && src_valid[k]) begin
                    fmt_q[k]     <= src_fmt[k];
                    illegal_q[k] <= src_illegal[k];
                    imm_q[k]     <= src_imm[k];
                    pc_q[k]      <= src_pc[k];
                end
            end
        end
    end

    assign in_ready    = load_ok[0];
    assign out_valid   = valid_q[LAST_STAGE];
    assign out_fmt     = fmt_q[LAST_STAGE];
    assign out_illegal = illegal_q[LAST_STAGE];
    assign out_imm     = imm_q[LAST_STAGE];
    // Wraps modulo 2^XLEN; meaningful only for B/J entries.
    assign out_target  = pc_q[LAST_STAGE] + imm_q[LAST_STAGE];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (32b/depth1, 32b/depth2, 64b/depth1),
// directed cases with fixed expectations plus randomized traffic against a
// field-extraction reference model and an in-order scoreboard.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] target;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_illegal_a;
    logic [31:0] out_imm_a, out_target_a;
    imm_fmt_e    out_fmt_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_illegal_b;
    logic [31:0] out_imm_b, out_target_b;
    imm_fmt_e    out_fmt_b;
    logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_illegal_c;
    logic [63:0] out_imm_c, out_target_c;
    imm_fmt_e    out_fmt_c;

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_instr(instr), .in_pc(pc[31:0]),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_imm(out_imm_a),
        .out_target(out_target_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a)
    );

    imm_gen_pipe #(.XLEN(32), .PIPE_DEPTH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_instr(instr), .in_pc(pc[31:0]),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_imm(out_imm_b),
        .out_target(out_target_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b)
    );

    imm_gen_pipe #(.XLEN(64), .PIPE_DEPTH(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .in_instr(instr), .in_pc(pc),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_imm(out_imm_c),
        .out_target(out_target_c), .out_fmt(out_fmt_c), .out_illegal(out_illegal_c)
    );

    // Reference: immediates built by shifting the sign-extended word and adding fields.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] p, input int xlen);
        exp_t        e;
        longint      s;
        longint      v;
        logic [63:0] mask;
        s         = longint'($signed(ins));
        mask      = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        v         = 0;
        e.illegal = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                e.fmt = FMT_I;
                v     = s >>> 20;
            end
            7'h23: begin
                e.fmt = FMT_S;
                v     = ((s >>> 25) <<< 5) + longint'(ins[11:7]);
            end
            7'h63: begin
                e.fmt = FMT_B;
                v     = ((s >>> 31) <<< 12) + longint'(ins[7]) * 2048 +
                        longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h37, 7'h17: begin
                e.fmt = FMT_U;
                v     = (s >>> 12) <<< 12;
            end
            7'h6F: begin
                e.fmt = FMT_J;
                v     = ((s >>> 31) <<< 20) + longint'(ins[19:12]) * 4096 +
                        longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'h33, 7'h3B: e.fmt = FMT_R;
            7'h1B: begin
                if (xlen == 64) begin
                    e.fmt = FMT_I;
                    v     = s >>> 20;
                end else begin
                    e.fmt     = FMT_NONE;
                    e.illegal = 1'b1;
                end
            end
            default: begin
                e.fmt     = FMT_NONE;
                e.illegal = 1'b1;
            end
        endcase
        e.imm    = 64'(v) & mask;
        e.target = (p + 64'(v)) & mask;
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] imm, input logic [63:0] target,
                                input logic [2:0] fmt, input logic ill);
        exp_t e;
        e.imm     = imm;
        e.target  = target;
        e.fmt     = fmt;
        e.illegal = ill;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [14] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h1B, 7'h7F};
        logic [31:0] w;
        int unsigned sel;
        logic [6:0]  op;
        w   = $urandom();
        sel = $urandom_range(0, 15);
        op  = (sel < 14) ? ops[sel] : w[6:0];
        return {w[31:7], op};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic [63:0] imm,
                             input logic [63:0] target, input logic [2:0] fmt, input logic ill);
        check({tag, ".imm"}, imm, e.imm);
        check({tag, ".target"}, target, e.target);
        check({tag, ".fmt"}, 64'(fmt), 64'(e.fmt));
        check({tag, ".illegal"}, 64'(ill), 64'(e.illegal));
    endtask

    // One entry through dut_a (depth 1): accepted now, valid exactly one edge later.
    task automatic send_a(input string tag, input logic [31:0] ins, input logic [63:0] p,
                          input exp_t e);
        @(negedge clk);
        instr = ins; pc = p; in_valid_a = 1'b1; out_ready_a = 1'b1;
        #1 check({tag, ".in_ready"}, 64'(in_ready_a), 64'd1);
        check({tag, ".pre_valid"}, 64'(out_valid_a), 64'd0);
        @(negedge clk);
        in_valid_a = 1'b0;
        #1 check({tag, ".out_valid"}, 64'(out_valid_a), 64'd1);
        check_out(tag, e, 64'(out_imm_a), 64'(out_target_a), out_fmt_a, out_illegal_a);
    endtask

    task automatic send_c(input string tag, input logic [31:0] ins, input logic [63:0] p,
                          input exp_t e);
        @(negedge clk);
        instr = ins; pc = p; in_valid_c = 1'b1; out_ready_c = 1'b1;
        @(negedge clk);
        in_valid_c = 1'b0;
        #1 check({tag, ".out_valid"}, 64'(out_valid_c), 64'd1);
        check_out(tag, e, out_imm_c, out_target_c, out_fmt_c, out_illegal_c);
    endtask

    initial begin
        exp_t e;
        int   sent;
        int   got;

        rst_n = 1'b0; flush = 1'b0; instr = '0; pc = '0;
        in_valid_a = 1'b0; out_ready_a = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b0;
        in_valid_c = 1'b0; out_ready_c = 1'b0;

        // Reset state.
        #3;
        check("reset.a.out_valid", 64'(out_valid_a), 64'd0);
        check_out("reset.a", mk(64'd0, 64'd0, FMT_NONE, 1'b0), 64'(out_imm_a),
                  64'(out_target_a), out_fmt_a, out_illegal_a);
        check("reset.b.out_valid", 64'(out_valid_b), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("reset.a.in_ready", 64'(in_ready_a), 64'd1);
        check("reset.b.in_ready", 64'(in_ready_b), 64'd1);

        // Directed formats, XLEN=32 depth 1.
        send_a("addi", 32'hFFF0_0093, 64'h0, mk(64'hFFFF_FFFF, 64'hFFFF_FFFF, FMT_I, 1'b0));
        send_a("sw", 32'hFE20_AC23, 64'h0, mk(64'hFFFF_FFF8, 64'hFFFF_FFF8, FMT_S, 1'b0));
        send_a("beq", 32'hFE00_0EE3, 64'h100, mk(64'hFFFF_FFFC, 64'h0000_00FC, FMT_B, 1'b0));
        send_a("jal", 32'h0080_006F, 64'h200, mk(64'h8, 64'h208, FMT_J, 1'b0));
        send_a("lui", 32'h1234_50B7, 64'h0, mk(64'h1234_5000, 64'h1234_5000, FMT_U, 1'b0));
        send_a("opc7f", 32'h0000_007F, 64'h40, mk(64'h0, 64'h40, FMT_NONE, 1'b1));
        send_a("addiw32", 32'hFFF0_009B, 64'h40, mk(64'h0, 64'h40, FMT_NONE, 1'b1));
        send_a("add", 32'h00B5_0533, 64'h40, mk(64'h0, 64'h40, FMT_R, 1'b0));

        // Randomized traffic on dut_a with random stalls.
        qa.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            in_valid_a  = ($urandom_range(0, 3) != 0);
            out_ready_a = ($urandom_range(0, 3) != 0) || (cyc >= 290);
            if (cyc >= 285) in_valid_a = 1'b0;
            instr = rand_instr();
            pc    = {32'h0, $urandom()};
            #1;
            if (out_valid_a) begin
                if (qa.size() == 0) begin
                    check("rand_a.spurious", 64'(out_valid_a), 64'd0);
                end else begin
                    check_out("rand_a", qa[0], 64'(out_imm_a), 64'(out_target_a), out_fmt_a,
                              out_illegal_a);
                    if (out_ready_a) void'(qa.pop_front());
                end
            end
            if (in_valid_a && in_ready_a) qa.push_back(model(instr, pc, 32));
        end
        check("rand_a.drained", 64'(qa.size()), 64'd0);

        // Backpressure, depth 2: consumer stalls 5 cycles while 4 entries stream.
        qb.delete(); sent = 0; got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid_b  = (sent < 4);
            out_ready_b = (cyc >= 5);
            instr = rand_instr();
            pc    = {32'h0, $urandom()};
            #1;
            if (cyc >= 2 && cyc < 5) check("bp.in_ready_low", 64'(in_ready_b), 64'd0);
            if (out_valid_b) begin
                if (qb.size() == 0) begin
                    check("bp.spurious", 64'(out_valid_b), 64'd0);
                end else begin
                    check_out(out_ready_b ? "bp.pop" : "bp.hold", qb[0], 64'(out_imm_b),
                              64'(out_target_b), out_fmt_b, out_illegal_b);
                    if (out_ready_b) begin
                        void'(qb.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid_b && in_ready_b) begin
                qb.push_back(model(instr, pc, 32));
                sent++;
            end
        end
        check("bp.delivered", 64'(got), 64'd4);
        in_valid_b = 1'b0;

        // Flush with two entries in flight plus a concurrent input.
        out_ready_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            instr = rand_instr(); pc = {32'h0, $urandom()}; in_valid_b = 1'b1;
        end
        @(negedge clk);
        flush = 1'b1; in_valid_b = 1'b1; instr = 32'h0080_006F; pc = 64'h300;
        #1 check("flush.pre_valid", 64'(out_valid_b), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b1;
        #1 check("flush.out_valid", 64'(out_valid_b), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 check("flush.no_ghost", 64'(out_valid_b), 64'd0);
        end
        @(negedge clk);
        instr = 32'hFE00_0EE3; pc = 64'h1000; in_valid_b = 1'b1;
        e = model(instr, pc, 32);
        #1 check("flush.after.in_ready", 64'(in_ready_b), 64'd1);
        @(negedge clk);
        in_valid_b = 1'b0;
        #1 check("flush.after.lat1", 64'(out_valid_b), 64'd0);
        @(negedge clk);
        #1 check("flush.after.lat2", 64'(out_valid_b), 64'd1);
        check_out("flush.after", e, 64'(out_imm_b), 64'(out_target_b), out_fmt_b, out_illegal_b);

        // Asynchronous reset while an entry is held at the output.
        @(negedge clk);
        instr = 32'hFFF0_0093; pc = 64'h0; in_valid_a = 1'b1; out_ready_a = 1'b0;
        @(negedge clk);
        in_valid_a = 1'b0;
        #1 check("arst.pre_valid", 64'(out_valid_a), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst.out_valid", 64'(out_valid_a), 64'd0);
        check("arst.out_imm", 64'(out_imm_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready_a = 1'b1;
        #1 check("arst.in_ready", 64'(in_ready_a), 64'd1);
        @(negedge clk);
        #1 check("arst.no_partial", 64'(out_valid_a), 64'd0);

        // XLEN=64 instance.
        send_c("beq64", 32'hFE00_0EE3, 64'h100,
               mk(64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_00FC, FMT_B, 1'b0));
        send_c("addiw64", 32'hFFF0_009B, 64'h0,
               mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0));
        send_c("lui64", 32'h8000_00B7, 64'h0,
               mk(64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0));
        for (int i = 0; i < 20; i++) begin
            logic [31:0] w;
            logic [63:0] p;
            w = rand_instr();
            p = {$urandom(), $urandom()};
            send_c("rand_c", w, p, model(w, p, 64));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
